// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 14-bit binary to 4-digit BCD converter (double dabble)
module bin_to_bcd_seq #(
  parameter logic [3:0] BLANK_CODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [13:0] bin_in,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3,
  output logic [3:0]  digit4
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t      state;
  logic [13:0] shift_reg;
  logic [15:0] scratch;
  logic [3:0]  iter;
  logic        ovf_cap;
  logic [15:0] adj;
  logic [29:0] shifted;
  // add-3 correction on every BCD nibble, then one left shift of the whole chain
  always_comb begin
    adj[3:0]   = scratch[3:0]   >= 4'd5 ? scratch[3:0]   + 4'd3 : scratch[3:0];
    adj[7:4]   = scratch[7:4]   >= 4'd5 ? scratch[7:4]   + 4'd3 : scratch[7:4];
    adj[11:8]  = scratch[11:8]  >= 4'd5 ? scratch[11:8]  + 4'd3 : scratch[11:8];
    adj[15:12] = scratch[15:12] >= 4'd5 ? scratch[15:12] + 4'd3 : scratch[15:12];
    shifted    = {adj, shift_reg} << 1;
  end
  // FSM: capture on start, 14 shift iterations, commit digits on the last one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      iter      <= '0;
      ovf_cap   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
      digit1    <= '0;
      digit2    <= '0;
      digit3    <= '0;
      digit4    <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          shift_reg <= bin_in;
          scratch   <= '0;
          iter      <= '0;
          ovf_cap   <= bin_in > 14'd9999;
          busy      <= 1'b1;
          state     <= SHIFT;
        end
      end else begin
        scratch   <= shifted[29:14];
        shift_reg <= shifted[13:0];
        iter      <= iter + 4'd1;
        if (iter == 4'd13) begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b1;
          overflow <= ovf_cap;
          digit1   <= ovf_cap ? BLANK_CODE : shifted[17:14];
          digit2   <= ovf_cap ? BLANK_CODE : shifted[21:18];
          digit3   <= ovf_cap ? BLANK_CODE : shifted[25:22];
          digit4   <= ovf_cap ? BLANK_CODE : shifted[29:26];
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized self-checking bench against an arithmetic decimal model
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] bin_in;
  logic        busy, done, overflow;
  logic [3:0]  digit1, digit2, digit3, digit4;
  logic [15:0] digits;
  int compared = 0;
  int mismatched = 0;

  bin_to_bcd_seq dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .overflow(overflow),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4)
  );

  always #10 clk = ~clk;
  assign digits = {digit4, digit3, digit2, digit1};

  function automatic logic [15:0] model(input int v);
    if (v > 9999) return 16'hFFFF;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int v);
    start = 1'b1;
    bin_in = 14'(v);
    tick();
    start = 1'b0;
    bin_in = 14'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (done !== 1'b1 && n < 40);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    start = 1'b0;
    bin_in = '0;
    tick();
    tick();
    compared++;
    if ({busy, done, overflow, digits} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_state: got busy=%b done=%b ovf=%b digits=%h, want all 0", busy, done, overflow, digits);
    end
    reset = 1'b0;
    tick();
    launch(0);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL zero_busy: got %b want 1", busy);
    end
    wait_done(n);
    compared++;
    if (n !== 14 || digits !== 16'h0000 || overflow !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_result: got lat=%0d digits=%h ovf=%b busy=%b, want 14/0000/0/0", n, digits, overflow, busy);
    end
    tick();
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL zero_done_width: got %b want 0", done);
    end
  endtask

  task automatic test_known();
    logic [15:0] prev;
    prev = digits;
    launch(1234);
    for (int i = 1; i < 14; i++) begin
      tick();
      compared++;
      if (busy !== 1'b1 || done !== 1'b0 || digits !== prev) begin
        mismatched++;
        $display("FAIL hold_1234 cyc%0d: got busy=%b done=%b digits=%h, want 1/0/%h", i, busy, done, digits, prev);
      end
    end
    tick();
    compared++;
    if (done !== 1'b1 || busy !== 1'b0 || digits !== 16'h1234 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL result_1234: got done=%b busy=%b digits=%h ovf=%b, want 1/0/1234/0", done, busy, digits, overflow);
    end
  endtask

  task automatic test_boundary();
    int n;
    int vals[2] = '{9999, 10000};
    foreach (vals[k]) begin
      tick();
      launch(vals[k]);
      wait_done(n);
      compared++;
      if (n !== 14 || digits !== model(vals[k]) || overflow !== (vals[k] > 9999)) begin
        mismatched++;
        $display("FAIL boundary_%0d: got lat=%0d digits=%h ovf=%b, want 14/%h/%b", vals[k], n, digits, overflow, model(vals[k]), vals[k] > 9999);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    tick();
    launch(5678);
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) begin
        start = 1'b1;
        bin_in = 14'd1111;
      end
      tick();
      start = 1'b0;
      if (done === 1'b1) dones++;
      compared++;
      if (done !== (i == 14)) begin
        mismatched++;
        $display("FAIL ignore_done cyc%0d: got %b want %b", i, done, i == 14);
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    compared++;
    if (dones !== 1 || digits !== 16'h5678 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL ignore_result: got dones=%0d digits=%h ovf=%b, want 1/5678/0", dones, digits, overflow);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    int dones = 0;
    launch(4321);
    for (int i = 0; i < 6; i++) tick();
    #3 reset = 1'b1;
    #1;
    compared++;
    if ({busy, done, overflow, digits} !== 19'd0) begin
      mismatched++;
      $display("FAIL abort_async: got busy=%b done=%b ovf=%b digits=%h, want all 0", busy, done, overflow, digits);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    compared++;
    if (dones !== 0 || digits !== 16'h0000) begin
      mismatched++;
      $display("FAIL abort_no_done: got dones=%0d digits=%h, want 0/0000", dones, digits);
    end
    launch(42);
    wait_done(n);
    compared++;
    if (n !== 14 || digits !== 16'h0042 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL abort_restart: got lat=%0d digits=%h ovf=%b, want 14/0042/0", n, digits, overflow);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    tick();
    start = 1'b1;
    bin_in = 14'd0;
    tick();
    for (int k = 0; k <= 20; k++) begin
      n = 0;
      do begin
        tick();
        n++;
        if (n == 1 && k > 0) begin
          compared++;
          if (done !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_width k=%0d: got done=%b want 0", k, done);
          end
        end
      end while (done !== 1'b1 && n < 40);
      compared++;
      if (n !== (k == 0 ? 14 : 15) || digits !== model(k) || overflow !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b k=%0d: got gap=%0d digits=%h ovf=%b, want %0d/%h/0", k, n, digits, overflow, k == 0 ? 14 : 15, model(k));
      end
      bin_in = 14'(k + 1);
    end
    start = 1'b0;
    tick();
    tick();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_stop: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_random();
    int n;
    int v;
    for (int k = 0; k < 12; k++) begin
      v = (k % 3 == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      launch(v);
      wait_done(n);
      compared++;
      if (n !== 14 || digits !== model(v) || overflow !== (v > 9999)) begin
        mismatched++;
        $display("FAIL random v=%0d: got lat=%0d digits=%h ovf=%b, want 14/%h/%b", v, n, digits, overflow, model(v), v > 9999);
      end
      if (k % 2 == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_boundary();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter BLANK_CODE, default 4'hF, is the nibble driven on all digits when the input is out of range.
REQ-002 clk  input  1  system clock, 50 MHz; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous active-high reset; clears all state immediately, independent of clk.
REQ-004 start  input  1  conversion request, sampled on posedge clk.
REQ-005 bin_in  input  14  unsigned binary value to convert, valid range 0-9999.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse marking that a conversion result has been committed.
REQ-008 overflow  output  1  high when the last committed request had bin_in > 9999.
REQ-009 digit1  output  4  BCD ones digit, feeds the display digit1 input.
REQ-010 digit2  output  4  BCD tens digit.
REQ-011 digit3  output  4  BCD hundreds digit.
REQ-012 digit4  output  4  BCD thousands digit.

Function
REQ-013 The block SHALL implement a sequential shift-and-add-3 (double-dabble) converter with a two-state FSM: IDLE and SHIFT.
REQ-014 In IDLE with start=1 at a posedge, the block SHALL capture bin_in into a 14-bit shift register, clear a 16-bit BCD scratch register, clear a 4-bit iteration counter, enter SHIFT, and drive busy=1 from that edge.
REQ-015 At each posedge in SHIFT, the block SHALL add 3 to every scratch BCD nibble >= 5, then shift {scratch, shift register} left by one bit, and increment the iteration counter.
REQ-016 After exactly 14 SHIFT iterations, the block SHALL return to IDLE and deassert busy on the edge that performs the 14th iteration.
REQ-017 The 14th-iteration edge SHALL commit the scratch result to digit1-digit4 and assert done for exactly one clk cycle.
REQ-018 Latency SHALL be fixed at 14 cycles from the start-sampling edge to the done-asserting edge, independent of the value.
REQ-019 digit1-digit4 SHALL hold their previously committed values throughout a conversion and update atomically only on the commit edge.
REQ-020 If the captured bin_in > 9999, the commit edge SHALL drive all four digits to BLANK_CODE and set overflow=1; otherwise overflow SHALL be 0 at commit.
REQ-021 overflow SHALL change only on commit edges or on reset.
REQ-022 The block SHALL ignore start while busy=1; no re-capture and no timing change occur.
REQ-023 The block SHALL accept a start that is high in the cycle where done=1, since the FSM is already in IDLE, and begin a new conversion on that edge.
REQ-024 The block SHALL NOT retrigger while start is held high in IDLE without first completing: a held start SHALL launch back-to-back conversions, one every 15 cycles.
REQ-025 bin_in SHALL be don't-care except on the start-sampling edge.

Reset
REQ-026 While reset=1, the block SHALL hold: state=IDLE, busy=0, done=0, overflow=0, digit1-digit4=0, scratch/shift/counter=0.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no done pulse, and the outputs SHALL read 0 rather than partial results.
REQ-028 After reset deasserts, the first start-sampling posedge SHALL behave as in REQ-014.

Verification
REQ-029 Reset, then start with bin_in=0 -> busy for 14 cycles, done pulse, digits 4/3/2/1 = 0/0/0/0, overflow=0.
REQ-030 bin_in=1234 -> after 14 cycles digit4=1, digit3=2, digit2=3, digit1=4; digits unchanged from the prior result until that edge.
REQ-031 bin_in=9999, then bin_in=10000 -> first gives 9/9/9/9 with overflow=0; second gives F/F/F/F with overflow=1.
REQ-032 Start with 5678, pulse start with 1111 at cycle 5 of busy -> result 5/6/7/8, only one done pulse, 1111 never appears.
REQ-033 Assert reset at cycle 7 of a 4321 conversion -> outputs immediately 0, no done; a subsequent start with 42 yields 0/0/4/2 after 14 cycles.
REQ-034 Hold start=1 while incrementing bin_in 0..20 each conversion -> done every 15 cycles, each result matches bin_in, done is never more than one cycle wide.
